enh_muldiv_unit: RTL and testbench

- Iterative multi-cycle multiply/divide engine on the enhanced-datapath side of the integer datapath's 64-bit operand bus.
- Consumes the registered operand pair {RS,RT} presented on that bus and returns a 64-bit {HI,LO} result with a start/busy/done handshake.
- Frees the integer ALU from single-cycle 32x32 multiply and divide. The MCU holds off the write-back until the unit reports DONE.

---
 rtl/enh_muldiv_unit.sv | 179 +++++++++++++++++
 tb/tb_enh_muldiv_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/enh_muldiv_unit.sv
// enh_muldiv_unit
//   Iterative multiply/divide engine that sits on the 64-bit operand bus.
//   It takes one {S,T} operand pair and returns a 2W-bit {HI,LO} result.
//   The unit spends W cycles iterating and one cycle on sign fix-up, then
//   pulses DONE for one cycle.
//
// Ports
//   CLK      clock, rising edge
//   RESET    synchronous active-low reset
//   START    request, accepted only while not busy (IDLE or DONE state)
//   OP       00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   LONG_IN  {S,T} operand pair, captured on the accepting edge
//   BUSY     high in RUN and FIX
//   DONE     one-cycle pulse when HI/LO carry a new result
//   DIV0     divide with T==0 (valid from DONE until the next FIX)
//   HI       product high word / remainder
//   LO       product low word / quotient
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | waiting for START
// RUN    | one shift-add or restoring-divide step per cycle, W cycles
// FIX    | sign correction, HI/LO/DIV0 load
// DONE   | result pulse; a new START is accepted here
module enh_muldiv_unit #(
    parameter int W = 32
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic           START,
    input  logic [1:0]     OP,
    input  logic [2*W-1:0] LONG_IN,
    output logic           BUSY,
    output logic           DONE,
    output logic           DIV0,
    output logic [W-1:0]   HI,
    output logic [W-1:0]   LO
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int            CW   = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic [1:0]     r_state;
    logic [1:0]     r_op;
    logic           r_sign_s;
    logic           r_sign_t;
    logic [W-1:0]   r_s_raw;
    logic [W-1:0]   r_mag_t;   // multiplicand or divisor magnitude
    logic [2*W-1:0] r_acc;     // mul: {partial, multiplier}; div: {0, dividend/quotient}
    logic [W:0]     r_rem;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_hi;
    logic [W-1:0]   r_lo;
    logic           r_div0;

    logic [W-1:0]   w_s;
    logic [W-1:0]   w_t;
    logic           w_neg_s;
    logic           w_neg_t;
    logic [W-1:0]   w_mag_s;
    logic [W-1:0]   w_mag_t;
    logic [W:0]     w_mul_sum;
    logic [2*W-1:0] w_mul_next;
    logic [W:0]     w_div_shift;
    logic [W+1:0]   w_div_diff;
    logic           w_div_ge;
    logic [W:0]     w_rem_next;
    logic [W-1:0]   w_quo_next;
    logic [2*W-1:0] w_prod_fix;
    logic [W-1:0]   w_quo_fix;
    logic [W-1:0]   w_rem_fix;
    logic           w_div_by_zero;
    logic           w_unused;

    // Operand capture: signed ops take two's-complement magnitudes.
    assign w_s     = LONG_IN[2*W-1:W];
    assign w_t     = LONG_IN[W-1:0];
    assign w_neg_s = OP[0] & w_s[W-1];
    assign w_neg_t = OP[0] & w_t[W-1];
    assign w_mag_s = w_neg_s ? (~w_s + 1'b1) : w_s;
    assign w_mag_t = w_neg_t ? (~w_t + 1'b1) : w_t;

    // Radix-2 shift-add: add multiplicand into the upper half on multiplier LSB,
    // then shift the whole accumulator right, carry included.
    assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_mag_t} : {(W+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[W-1:1]};

    // Restoring divide: shift next dividend bit into the remainder, trial subtract.
    assign w_div_shift = {r_rem[W-1:0], r_acc[W-1]};
    assign w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_mag_t};
    assign w_div_ge    = ~w_div_diff[W+1];
    assign w_rem_next  = w_div_ge ? w_div_diff[W:0] : w_div_shift;
    assign w_quo_next  = {r_acc[W-2:0], w_div_ge};

    // Sign flags are only ever set for signed ops, so no OP check is needed here.
    assign w_prod_fix    = (r_sign_s ^ r_sign_t) ? (~r_acc + 1'b1) : r_acc;
    assign w_quo_fix     = (r_sign_s ^ r_sign_t) ? (~r_acc[W-1:0] + 1'b1) : r_acc[W-1:0];
    assign w_rem_fix     = r_sign_s ? (~r_rem[W-1:0] + 1'b1) : r_rem[W-1:0];
    assign w_div_by_zero = (r_mag_t == {W{1'b0}});

    // The remainder never exceeds the divisor once stored, so its top bit is dead.
    assign w_unused = r_rem[W];

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state  <= S_IDLE;
            r_op     <= 2'b00;
            r_sign_s <= 1'b0;
            r_sign_t <= 1'b0;
            r_s_raw  <= {W{1'b0}};
            r_mag_t  <= {W{1'b0}};
            r_acc    <= {(2*W){1'b0}};
            r_rem    <= {(W+1){1'b0}};
            r_cnt    <= {CW{1'b0}};
            r_hi     <= {W{1'b0}};
            r_lo     <= {W{1'b0}};
            r_div0   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (START) begin
                        r_op     <= OP;
                        r_sign_s <= w_neg_s;
                        r_sign_t <= w_neg_t;
                        r_s_raw  <= w_s;
                        r_mag_t  <= w_mag_t;
                        r_acc    <= {{W{1'b0}}, w_mag_s};
                        r_rem    <= {(W+1){1'b0}};
                        r_cnt    <= {CW{1'b0}};
                        r_state  <= S_RUN;
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (r_op[1]) begin
                        r_acc <= {r_acc[2*W-1:W], w_quo_next};
                        r_rem <= w_rem_next;
                    end else begin
                        r_acc <= w_mul_next;
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (!r_op[1]) begin
                        r_hi   <= w_prod_fix[2*W-1:W];
                        r_lo   <= w_prod_fix[W-1:0];
                        r_div0 <= 1'b0;
                    end else if (w_div_by_zero) begin
                        r_hi   <= r_s_raw;
                        r_lo   <= {W{1'b1}};
                        r_div0 <= 1'b1;
                    end else begin
                        r_hi   <= w_rem_fix;
                        r_lo   <= w_quo_fix;
                        r_div0 <= 1'b0;
                    end
                    r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign BUSY = (r_state == S_RUN) || (r_state == S_FIX);
    assign DONE = (r_state == S_DONE);
    assign DIV0 = r_div0;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule

// File: tb/tb_enh_muldiv_unit.sv
module tb_enh_muldiv_unit;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        START = 1'b0;
    logic [1:0]  OP = 2'b00;
    logic [63:0] LONG_IN = 64'h0;
    logic        BUSY;
    logic        DONE;
    logic        DIV0;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int errors = 0;
    logic [64:0] exp_q[$];   // {div0, hi, lo}

    enh_muldiv_unit #(.W(32)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .OP(OP), .LONG_IN(LONG_IN),
        .BUSY(BUSY), .DONE(DONE), .DIV0(DIV0), .HI(HI), .LO(LO)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives START for one edge, then scrambles LONG_IN/OP so that a unit
    // which fails to capture them produces a wrong result.
    task automatic start_op(input logic [1:0] op, input logic [31:0] s, input logic [31:0] t,
                            input logic [63:0] exp_hilo, input logic exp_div0);
        @(negedge CLK);
        START   = 1'b1;
        OP      = op;
        LONG_IN = {s, t};
        @(posedge CLK);
        #1;
        START   = 1'b0;
        LONG_IN = ~LONG_IN;
        OP      = ~op;
        exp_q.push_back({exp_div0, exp_hilo});
    endtask

    // Counts edges from the START edge until DONE; optionally injects a
    // conflicting START while the unit is busy.
    task automatic wait_done(input string tag, input int inject_at);
        int n = 0;
        int busy_n = 0;
        logic [64:0] e;
        while (!DONE && n < 100) begin
            if (BUSY) busy_n++;
            if (n == inject_at) begin
                START   = 1'b1;
                OP      = 2'b11;
                LONG_IN = 64'h00000005_00000003;
            end else begin
                START = 1'b0;
            end
            @(posedge CLK);
            #1;
            n++;
        end
        START = 1'b0;
        chk({tag, " latency"}, 64'(n), 64'd33);
        chk({tag, " busy_cycles"}, 64'(busy_n), 64'd33);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, " HI"}, {32'h0, HI}, {32'h0, e[63:32]});
            chk({tag, " LO"}, {32'h0, LO}, {32'h0, e[31:0]});
            chk({tag, " DIV0"}, {63'h0, DIV0}, {63'h0, e[64]});
        end else begin
            chk({tag, " scoreboard_empty"}, 64'(exp_q.size()), 64'd1);
        end
    endtask

    task automatic pulse_check(input string tag);
        logic [63:0] hold;
        hold = {HI, LO};
        @(posedge CLK);
        #1;
        chk({tag, " done_pulse"}, {63'h0, DONE}, 64'h0);
        chk({tag, " hold"}, {HI, LO}, hold);
    endtask

    initial begin
        int seen;

        RESET = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset BUSY", {63'h0, BUSY}, 64'h0);
        chk("reset DONE", {63'h0, DONE}, 64'h0);
        chk("reset DIV0", {63'h0, DIV0}, 64'h0);
        chk("reset HILO", {HI, LO}, 64'h0);
        @(negedge CLK);
        RESET = 1'b1;

        start_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0);
        wait_done("multu_max", -1);
        pulse_check("multu_max");

        start_op(2'b00, 32'h00010000, 32'h00030000, 64'h00000003_00000000, 1'b0);
        wait_done("multu_ignore_start", 5);
        pulse_check("multu_ignore_start");

        start_op(2'b01, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB, 1'b0);
        wait_done("mult_neg3x7", -1);

        start_op(2'b01, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0);
        wait_done("mult_minxmin", -1);

        start_op(2'b11, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
        wait_done("div_neg7by2", -1);

        start_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0);
        wait_done("div_min_by_m1", -1);

        start_op(2'b10, 32'h00000064, 32'h00000000, 64'h00000064_FFFFFFFF, 1'b1);
        wait_done("divu_by0", -1);
        pulse_check("divu_by0");

        start_op(2'b10, 32'h00000064, 32'h00000007, 64'h00000002_0000000E, 1'b0);
        wait_done("divu_100by7", -1);

        // Back-to-back: second START is driven while the first DONE is high.
        start_op(2'b00, 32'h00000007, 32'h00000006, 64'h00000000_0000002A, 1'b0);
        wait_done("b2b_first", -1);
        start_op(2'b11, 32'hFFFFFF9C, 32'h00000007, 64'hFFFFFFFE_FFFFFFF2, 1'b0);
        wait_done("b2b_second", -1);

        // Abort in the middle of RUN.
        start_op(2'b00, 32'hFFFFFFFF, 32'h00000002, 64'h00000001_FFFFFFFE, 1'b0);
        repeat (10) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        void'(exp_q.pop_back());
        chk("abort BUSY", {63'h0, BUSY}, 64'h0);
        chk("abort DONE", {63'h0, DONE}, 64'h0);
        chk("abort DIV0", {63'h0, DIV0}, 64'h0);
        chk("abort HILO", {HI, LO}, 64'h0);
        seen = 0;
        repeat (40) begin
            @(posedge CLK);
            #1;
            if (DONE || BUSY) seen++;
        end
        chk("abort no_done", 64'(seen), 64'h0);
        chk("scoreboard drained", 64'(exp_q.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
